// File: rtl/bit_interleaver.sv
// Two-step 802.16 OFDM bit interleaver: ping-pong banks, written in permuted order, read linearly.
// Optional feature: define INTLV_LAST_EN to add the out_last end-of-block marker port.
module bit_interleaver #(
  parameter int NCBPS_MAX = 1152,
  parameter int D         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mod_sel,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef INTLV_LAST_EN
  output logic       out_last,
`endif
  output logic [1:0] out_mod
);

  localparam int AW = $clog2(NCBPS_MAX + 1);
  localparam int MW = $clog2(2 * NCBPS_MAX);
  localparam int RW = $clog2(D);
  localparam int QW = AW - RW;

  typedef enum logic {RD_IDLE = 1'b0, RD_RUN = 1'b1} rd_state_t;

  function automatic logic [AW-1:0] blk_len(input logic [1:0] mod);
    case (mod)
      2'd0:    blk_len = AW'(192);
      2'd1:    blk_len = AW'(384);
      2'd2:    blk_len = AW'(768);
      default: blk_len = AW'(1152);
    endcase
  endfunction

  function automatic logic [AW-1:0] blk_cols(input logic [1:0] mod);
    case (mod)
      2'd0:    blk_cols = AW'(12);
      2'd1:    blk_cols = AW'(24);
      2'd2:    blk_cols = AW'(48);
      default: blk_cols = AW'(72);
    endcase
  endfunction

  function automatic logic [1:0] blk_s(input logic [1:0] mod);
    case (mod)
      2'd0:    blk_s = 2'd1;
      2'd1:    blk_s = 2'd1;
      2'd2:    blk_s = 2'd2;
      default: blk_s = 2'd3;
    endcase
  endfunction

  logic            r_mem [2*NCBPS_MAX];
  logic            r_wr_bank;
  logic [AW-1:0]   r_k;
  logic [RW-1:0]   r_r;
  logic [QW-1:0]   r_q;
  logic [AW-1:0]   r_m;
  logic [1:0]      r_qmod;
  logic [1:0]      r_rmod;
  logic [1:0]      r_wr_mod;
  logic [1:0]      r_full;
  logic [1:0][1:0] r_bank_mod;
  logic            r_in_ready;

  rd_state_t       r_rd_state;
  rd_state_t       w_rd_state_nxt;
  logic            r_rd_bank;
  logic [AW-1:0]   r_rd_addr;
  logic            r_out_valid;
  logic            r_out_bit;
  logic [1:0]      r_out_mod;

  logic            w_wr_en;
  logic [1:0]      w_mod_eff;
  logic [AW-1:0]   w_wr_n;
  logic [AW-1:0]   w_wr_cols;
  logic [1:0]      w_wr_s;
  logic            w_wr_last;
  logic [1:0]      w_jofs;
  logic [AW-1:0]   w_j;
  logic [MW-1:0]   w_wr_idx;
  logic [1:0]      w_full_set;
  logic [1:0]      w_full_clr;
  logic [1:0]      w_full_nxt;
  logic            w_wr_bank_nxt;
  logic [AW-1:0]   w_rd_n;
  logic [AW-1:0]   w_rd_addr_nxt;
  logic            w_rd_bank_nxt;
  logic            w_out_valid_nxt;
  logic            w_load;
  logic            w_load_bank;
  logic [AW-1:0]   w_load_addr;
  logic            w_rd_done;
  logic [MW-1:0]   w_rd_idx;

  // Write address: m mod s equals q mod s because N/16 is a multiple of s, so only q and r residues are tracked.
  always_comb begin
    w_wr_en = in_valid & r_in_ready;
    if (r_k == AW'(0)) begin
      w_mod_eff = mod_sel;
    end else begin
      w_mod_eff = r_wr_mod;
    end
    w_wr_n    = blk_len(w_mod_eff);
    w_wr_cols = blk_cols(w_mod_eff);
    w_wr_s    = blk_s(w_mod_eff);
    w_wr_last = (r_k == (w_wr_n - AW'(1)));
    if (r_qmod >= r_rmod) begin
      w_jofs = r_qmod - r_rmod;
    end else begin
      w_jofs = r_qmod + w_wr_s - r_rmod;
    end
    w_j = r_m - AW'(r_qmod) + AW'(w_jofs);
    if (r_wr_bank) begin
      w_wr_idx = MW'(NCBPS_MAX) + MW'(w_j);
    end else begin
      w_wr_idx = MW'(w_j);
    end
  end

  // Bank full flags: a completing write and a finishing read on the same edge both take effect.
  always_comb begin
    w_full_set    = (w_wr_en && w_wr_last) ? (2'b01 << r_wr_bank) : 2'b00;
    w_full_clr    = w_rd_done ? (2'b01 << r_rd_bank) : 2'b00;
    w_full_nxt    = (r_full & ~w_full_clr) | w_full_set;
    w_wr_bank_nxt = r_wr_bank ^ (w_wr_en & w_wr_last);
  end

  // Write index counters k, r, q, m and residues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_bank  <= 1'b0;
      r_k        <= AW'(0);
      r_r        <= RW'(0);
      r_q        <= QW'(0);
      r_m        <= AW'(0);
      r_qmod     <= 2'd0;
      r_rmod     <= 2'd0;
      r_wr_mod   <= 2'd0;
      r_bank_mod <= 4'd0;
    end else if (w_wr_en) begin
      if (r_k == AW'(0)) begin
        r_wr_mod              <= mod_sel;
        r_bank_mod[r_wr_bank] <= mod_sel;
      end
      if (w_wr_last) begin
        r_k       <= AW'(0);
        r_r       <= RW'(0);
        r_q       <= QW'(0);
        r_m       <= AW'(0);
        r_qmod    <= 2'd0;
        r_rmod    <= 2'd0;
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_k <= r_k + AW'(1);
        if (r_r == RW'(D - 1)) begin
          r_r    <= RW'(0);
          r_q    <= r_q + QW'(1);
          r_m    <= AW'(r_q) + AW'(1);
          r_qmod <= (r_qmod == (w_wr_s - 2'd1)) ? 2'd0 : (r_qmod + 2'd1);
          r_rmod <= 2'd0;
        end else begin
          r_r    <= r_r + RW'(1);
          r_m    <= r_m + w_wr_cols;
          r_rmod <= (r_rmod == (w_wr_s - 2'd1)) ? 2'd0 : (r_rmod + 2'd1);
        end
      end
    end
  end

  // Full flags and registered in_ready for the bank the write side will target next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full     <= 2'b00;
      r_in_ready <= 1'b0;
    end else begin
      r_full     <= w_full_nxt;
      r_in_ready <= ~w_full_nxt[w_wr_bank_nxt];
    end
  end

  // Bank storage write port.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= in_bit;
    end
  end

  // Read FSM: one idle cycle before a fresh block; chains straight into the other bank when it is already full.
  always_comb begin
    w_rd_state_nxt  = r_rd_state;
    w_rd_bank_nxt   = r_rd_bank;
    w_rd_addr_nxt   = r_rd_addr;
    w_out_valid_nxt = r_out_valid;
    w_load          = 1'b0;
    w_load_bank     = r_rd_bank;
    w_load_addr     = r_rd_addr;
    w_rd_done       = 1'b0;
    w_rd_n          = blk_len(r_bank_mod[r_rd_bank]);
    case (r_rd_state)
      RD_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_rd_state_nxt = RD_RUN;
          w_rd_addr_nxt  = AW'(0);
        end else begin
          w_rd_state_nxt = RD_IDLE;
        end
      end
      RD_RUN: begin
        if (r_rd_addr != w_rd_n) begin
          if (!r_out_valid || out_ready) begin
            w_load          = 1'b1;
            w_rd_addr_nxt   = r_rd_addr + AW'(1);
            w_out_valid_nxt = 1'b1;
          end else begin
            w_load = 1'b0;
          end
        end else if (r_out_valid && out_ready) begin
          w_rd_done     = 1'b1;
          w_rd_bank_nxt = ~r_rd_bank;
          if (r_full[~r_rd_bank]) begin
            w_load          = 1'b1;
            w_load_bank     = ~r_rd_bank;
            w_load_addr     = AW'(0);
            w_rd_addr_nxt   = AW'(1);
            w_out_valid_nxt = 1'b1;
          end else begin
            w_rd_state_nxt  = RD_IDLE;
            w_rd_addr_nxt   = AW'(0);
            w_out_valid_nxt = 1'b0;
          end
        end else begin
          w_rd_done = 1'b0;
        end
      end
      default: begin
        w_rd_state_nxt = RD_IDLE;
      end
    endcase
    if (w_load_bank) begin
      w_rd_idx = MW'(NCBPS_MAX) + MW'(w_load_addr);
    end else begin
      w_rd_idx = MW'(w_load_addr);
    end
  end

  // Read state and registered output stage; out_bit only changes on a load, so it holds while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_state  <= RD_IDLE;
      r_rd_bank   <= 1'b0;
      r_rd_addr   <= AW'(0);
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_mod   <= 2'd0;
    end else begin
      r_rd_state  <= w_rd_state_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_load) begin
        r_out_bit <= r_mem[w_rd_idx];
        r_out_mod <= r_bank_mod[w_load_bank];
      end
    end
  end

`ifdef INTLV_LAST_EN
  logic r_out_last;

  // End-of-block marker travels with the bit loaded from address N-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_last <= 1'b0;
    end else if (w_load) begin
      r_out_last <= (w_load_addr == (w_rd_n - AW'(1)));
    end else if (!w_out_valid_nxt) begin
      r_out_last <= 1'b0;
    end
  end

  assign out_last = r_out_last;
`endif

  assign in_ready  = r_in_ready;
  assign out_bit   = r_out_bit;
  assign out_valid = r_out_valid;
  assign out_mod   = r_out_mod;

endmodule

// File: tb/tb_bit_interleaver.sv
// Directed bench for bit_interleaver: one-hot positions, back-to-back blocks, stall, mod change, resets.
`timescale 1ns/1ps
module tb_bit_interleaver;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mod_sel;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_mod;
`ifdef INTLV_LAST_EN
  logic       out_last;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit       rx_bit[$];
  bit [1:0] rx_mod[$];
  bit       rx_last[$];
  int       rx_cyc[$];
  bit       exp_bit[$];
  bit [1:0] exp_mod[$];
  bit       exp_last[$];

  always #5 clk = ~clk;

  bit_interleaver dut (
    .clk       (clk),
    .reset     (reset),
    .mod_sel   (mod_sel),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef INTLV_LAST_EN
    .out_last  (out_last),
`endif
    .out_mod   (out_mod)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      rx_bit.push_back(out_bit);
      rx_mod.push_back(out_mod);
      rx_cyc.push_back(cyc);
`ifdef INTLV_LAST_EN
      rx_last.push_back(out_last);
`else
      rx_last.push_back(1'b0);
`endif
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nlen(input logic [1:0] mod);
    case (mod)
      2'd0: return 192;
      2'd1: return 384;
      2'd2: return 768;
      default: return 1152;
    endcase
  endfunction

  function automatic int ns(input logic [1:0] mod);
    case (mod)
      2'd2: return 2;
      2'd3: return 3;
      default: return 1;
    endcase
  endfunction

  // Reference permutation written straight from the two-step formula.
  function automatic int intlv_pos(input int k, input int n, input int s);
    int m;
    m = (n / 16) * (k % 16) + k / 16;
    return s * (m / s) + (m + n - (16 * m) / n) % s;
  endfunction

  function automatic int first_one();
    for (int i = 0; i < rx_bit.size(); i++) if (rx_bit[i]) return i;
    return -1;
  endfunction

  function automatic int count_ones();
    int c = 0;
    for (int i = 0; i < rx_bit.size(); i++) c += int'(rx_bit[i]);
    return c;
  endfunction

  task automatic send_block(input logic [1:0] mod, input logic [1:0] mod_late, input int hot,
                            input int seed, input int nsend, output int stalls);
    int n, k, guard;
    bit acc;
    bit blk[1152];
    bit gold[1152];
    n = nlen(mod);
    for (int i = 0; i < n; i++)
      blk[i] = (hot >= 0) ? (i == hot) : bit'(((i * i + 3 * i + seed) >> 2) & 1);
    stalls = 0;
    k = 0;
    guard = 0;
    while (k < nsend && guard < 20000) begin
      mod_sel  = (k == 0) ? mod : mod_late;
      in_bit   = blk[k];
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      else stalls++;
      guard++;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
    check_eq("in_accept", k, nsend);
    if (nsend == n) begin
      for (int i = 0; i < n; i++) gold[intlv_pos(i, n, ns(mod))] = blk[i];
      for (int i = 0; i < n; i++) begin
        exp_bit.push_back(gold[i]);
        exp_mod.push_back(mod);
        exp_last.push_back(i == n - 1);
      end
    end
  endtask

  task automatic wait_rx(input int budget);
    int t = 0;
    while (rx_bit.size() < exp_bit.size() && t < budget) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_clear(input string tag);
    int nmin;
    check_eq({tag, "_len"}, rx_bit.size(), exp_bit.size());
    nmin = (rx_bit.size() < exp_bit.size()) ? rx_bit.size() : exp_bit.size();
    for (int i = 0; i < nmin; i++) begin
      check_eq($sformatf("%s_bit%0d", tag, i), rx_bit[i], exp_bit[i]);
      check_eq($sformatf("%s_mod%0d", tag, i), rx_mod[i], exp_mod[i]);
`ifdef INTLV_LAST_EN
      check_eq($sformatf("%s_last%0d", tag, i), rx_last[i], exp_last[i]);
`endif
    end
    rx_bit.delete(); rx_mod.delete(); rx_last.delete(); rx_cyc.delete();
    exp_bit.delete(); exp_mod.delete(); exp_last.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_bit"}, out_bit, 0);
    check_eq({tag, "_out_mod"}, out_mod, 0);
`ifdef INTLV_LAST_EN
    check_eq({tag, "_out_last"}, out_last, 0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, st2, lat, diffs, t;
    bit b0;
    logic [1:0] oh_mod[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    int oh_hot[4] = '{1, 17, 1, 1};
    int oh_pos[4] = '{12, 25, 49, 74};

    reset = 1'b0; mod_sel = 2'd0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("rst");
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check_eq("rdy_pre", in_ready, 0);
    @(negedge clk);
    check_eq("rdy_post", in_ready, 1);
    @(posedge clk); #1;

    for (int t2 = 0; t2 < 4; t2++) begin
      send_block(oh_mod[t2], oh_mod[t2], oh_hot[t2], 0, nlen(oh_mod[t2]), st);
      if (t2 == 0) begin
        lat = 0;
        while (lat < 20) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (out_valid) break;
        end
        check_eq("latency", lat, 2);
      end
      wait_rx(3000);
      check_eq($sformatf("onehot%0d_pos", t2), first_one(), oh_pos[t2]);
      check_eq($sformatf("onehot%0d_ones", t2), count_ones(), 1);
      compare_clear($sformatf("onehot%0d", t2));
    end

    send_block(2'd1, 2'd1, -1, 3, 384, st);
    send_block(2'd1, 2'd1, -1, 4, 384, st2);
    check_eq("b2b_stall2", st2, 0);
    send_block(2'd1, 2'd1, -1, 5, 384, st);
    wait_rx(3000);
    check_eq("b2b_contig", rx_cyc[384] - rx_cyc[383], 1);
    compare_clear("b2b");

    out_ready = 1'b0;
    send_block(2'd3, 2'd3, -1, 21, 1152, st);
    send_block(2'd3, 2'd3, -1, 22, 1152, st);
    @(negedge clk);
    check_eq("stall_in_ready", in_ready, 0);
    check_eq("stall_out_valid", out_valid, 1);
    b0 = out_bit;
    diffs = 0;
    repeat (2000) begin
      @(negedge clk);
      if (out_bit !== b0 || out_valid !== 1'b1 || in_ready !== 1'b0) diffs++;
    end
    check_eq("stall_stable", diffs, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_block(2'd3, 2'd3, -1, 23, 1152, st);
    check_eq("stall_c_waited", st > 0, 1);
    wait_rx(6000);
    compare_clear("stall");

    send_block(2'd0, 2'd3, -1, 7, 192, st);
    send_block(2'd2, 2'd0, -1, 9, 768, st);
    wait_rx(3000);
    check_eq("modchg_first", rx_mod[0], 0);
    check_eq("modchg_second", rx_mod[192], 2);
    compare_clear("modchg");

    send_block(2'd1, 2'd1, -1, 5, 100, st);
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("rstw");
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    send_block(2'd1, 2'd1, -1, 11, 384, st);
    wait_rx(3000);
    compare_clear("rstw");

    send_block(2'd2, 2'd2, -1, 13, 768, st);
    t = 0;
    while (rx_bit.size() < 100 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1; reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("rstr");
    rx_bit.delete(); rx_mod.delete(); rx_last.delete(); rx_cyc.delete();
    exp_bit.delete(); exp_mod.delete(); exp_last.delete();
    @(posedge clk); #1; reset = 1'b1;
    repeat (50) @(posedge clk);
    check_eq("rstr_quiet", rx_bit.size(), 0);
    #1;
    send_block(2'd3, 2'd3, -1, 17, 1152, st);
    wait_rx(4000);
    compare_clear("rstr");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
